// File: rtl/bicubic_pkg.sv
// Shared types and constants for the bicubic tap loaders: FSM encodings,
// Q0.8 constants, horizontal tap offsets and the Q0.8 rounding multiply.
package bicubic_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_LAST  = 3'd2,
        S_START = 3'd3,
        S_WAIT  = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    localparam logic [7:0]  ONE_Q08  = 8'hFF;
    localparam logic [15:0] HALF_Q08 = 16'd128;

    localparam logic signed [3:0] TAP_OFF [4] = '{-4'sd1, 4'sd0, 4'sd1, 4'sd2};

    // Q0.8 x Q0.8 with round-half-up; 255*255+128 still fits in 16 bits.
    function automatic logic [7:0] mul_q08(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = ({8'd0, a} * {8'd0, b}) + HALF_Q08;
        return prod[15:8];
    endfunction

endpackage

// File: rtl/bicubic_border_map.sv
// Maps a signed tap column onto a legal image column.
// Default build clamps; defining BORDER_MIRROR_EN selects mirror without edge repeat.
module bicubic_border_map
    import bicubic_pkg::*;
#(
    parameter int COL_W = 6,
    parameter int IMG_W = 64
) (
    input  logic signed [COL_W+1:0] col_in,
    output logic [COL_W-1:0]        col_out
);

    localparam int MAX_I = IMG_W - 1;
    localparam logic signed [COL_W+1:0] MAX_C = MAX_I[COL_W+1:0];
    localparam logic [COL_W-1:0]        MAX_U = MAX_I[COL_W-1:0];
`ifdef BORDER_MIRROR_EN
    localparam int MAX2_I = 2 * (IMG_W - 1);
    localparam logic [COL_W-1:0] MAX2_U = MAX2_I[COL_W-1:0];
`endif

    // Out-of-range columns only ever lie within two pixels of an edge, so the
    // mirrored result is exact when computed modulo 2^COL_W.
    always_comb begin
        col_out = col_in[COL_W-1:0];
        if (col_in[COL_W+1]) begin
`ifdef BORDER_MIRROR_EN
            col_out = (~col_in[COL_W-1:0]) + {{(COL_W-1){1'b0}}, 1'b1};
`else
            col_out = {COL_W{1'b0}};
`endif
        end else if (col_in > MAX_C) begin
`ifdef BORDER_MIRROR_EN
            col_out = MAX2_U - col_in[COL_W-1:0];
`else
            col_out = MAX_U;
`endif
        end else begin
            col_out = col_in[COL_W-1:0];
        end
    end

endmodule

// File: rtl/bicubic_tap_loader.sv
// Request-to-engine feeder: fetches four horizontal taps, builds {t^3,t^2,t,1},
// runs the bicubic engine and presents its result. Border mode: BORDER_MIRROR_EN.
module bicubic_tap_loader
    import bicubic_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int COL_W  = 6,
    parameter int ROW_W  = 6,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [COL_W-1:0]  req_col,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [7:0]        req_frac,
    output logic              mem_ren,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [31:0]       eng_x,
    output logic [31:0]       eng_p,
    output logic              eng_start,
    input  logic              eng_finish,
    input  logic [7:0]        eng_out_val,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [7:0]        res_data
);

    if (ADDR_W != COL_W + ROW_W || IMG_W != (1 << COL_W) || IMG_H > (1 << ROW_W)) begin : g_bad_params
        $error("bicubic_tap_loader: inconsistent image geometry parameters");
    end

    state_t                   state_r, next_state_s;
    logic [1:0]               cnt_r;
    logic [COL_W-1:0]         col_r;
    logic [ROW_W-1:0]         row_r;
    logic                     accept_s;
    logic [COL_W-1:0]         base_col_s;
    logic [ROW_W-1:0]         base_row_s;
    logic [1:0]               tap_idx_s;
    logic signed [3:0]        tap_off_s;
    logic signed [COL_W+1:0]  tap_col_s;
    logic [COL_W-1:0]         map_col_s;

    logic                     req_ready_r;
    logic                     mem_ren_r;
    logic [ADDR_W-1:0]        mem_addr_r;
    logic [31:0]              eng_x_r;
    logic [31:0]              eng_p_r;
    logic                     eng_start_r;
    logic                     res_valid_r;
    logic [7:0]               res_data_r;

    assign req_ready = req_ready_r;
    assign mem_ren   = mem_ren_r;
    assign mem_addr  = mem_addr_r;
    assign eng_x     = eng_x_r;
    assign eng_p     = eng_p_r;
    assign eng_start = eng_start_r;
    assign res_valid = res_valid_r;
    assign res_data  = res_data_r;

    assign accept_s = (state_r == S_IDLE) && req_valid && req_ready_r;

    // Address of the next tap to issue: tap 0 straight from the request, later taps from the latch.
    always_comb begin
        base_col_s = col_r;
        base_row_s = row_r;
        tap_idx_s  = cnt_r + 2'd1;
        if (accept_s) begin
            base_col_s = req_col;
            base_row_s = req_row;
            tap_idx_s  = 2'd0;
        end else begin
            base_col_s = col_r;
            base_row_s = row_r;
            tap_idx_s  = cnt_r + 2'd1;
        end
        tap_off_s = TAP_OFF[tap_idx_s];
        tap_col_s = $signed({2'b00, base_col_s}) + $signed({{(COL_W-2){tap_off_s[3]}}, tap_off_s});
    end

    bicubic_border_map #(
        .COL_W (COL_W),
        .IMG_W (IMG_W)
    ) u_border_map (
        .col_in  (tap_col_s),
        .col_out (map_col_s)
    );

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE:  if (accept_s)          next_state_s = S_RD;    else next_state_s = S_IDLE;
            S_RD:    if (cnt_r == 2'd3)     next_state_s = S_LAST;  else next_state_s = S_RD;
            S_LAST:                         next_state_s = S_START;
            S_START:                        next_state_s = S_WAIT;
            S_WAIT:  if (eng_finish)        next_state_s = S_OUT;   else next_state_s = S_WAIT;
            S_OUT:   if (res_ready)         next_state_s = S_IDLE;  else next_state_s = S_OUT;
            default:                        next_state_s = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Datapath registers and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r       <= 2'd0;
            col_r       <= {COL_W{1'b0}};
            row_r       <= {ROW_W{1'b0}};
            req_ready_r <= 1'b0;
            mem_ren_r   <= 1'b0;
            mem_addr_r  <= {ADDR_W{1'b0}};
            eng_x_r     <= 32'd0;
            eng_p_r     <= 32'd0;
            eng_start_r <= 1'b0;
            res_valid_r <= 1'b0;
            res_data_r  <= 8'd0;
        end else begin
            req_ready_r <= (next_state_s == S_IDLE);
            eng_start_r <= (state_r == S_LAST);
            cnt_r       <= (state_r == S_RD) ? cnt_r + 2'd1 : 2'd0;
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        col_r      <= req_col;
                        row_r      <= req_row;
                        eng_x_r    <= {ONE_Q08, req_frac, 8'd0, 8'd0};
                        mem_ren_r  <= 1'b1;
                        mem_addr_r <= {base_row_s, map_col_s};
                    end
                end
                S_RD: begin
                    if (cnt_r == 2'd3) begin
                        mem_ren_r <= 1'b0;
                    end else begin
                        mem_ren_r  <= 1'b1;
                        mem_addr_r <= {base_row_s, map_col_s};
                    end
                    // SRAM data lags the address by one cycle, so tap cnt-1 lands now.
                    case (cnt_r)
                        2'd0: eng_x_r[15:8] <= mul_q08(eng_x_r[23:16], eng_x_r[23:16]);
                        2'd1: begin
                            eng_x_r[7:0] <= mul_q08(eng_x_r[15:8], eng_x_r[23:16]);
                            eng_p_r[7:0] <= mem_rdata;
                        end
                        2'd2:    eng_p_r[15:8]  <= mem_rdata;
                        2'd3:    eng_p_r[23:16] <= mem_rdata;
                        default: eng_p_r        <= eng_p_r;
                    endcase
                end
                S_LAST: eng_p_r[31:24] <= mem_rdata;
                S_WAIT: begin
                    if (eng_finish) begin
                        res_data_r  <= eng_out_val;
                        res_valid_r <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (res_ready) begin
                        res_valid_r <= 1'b0;
                    end
                end
                default: res_valid_r <= res_valid_r;
            endcase
        end
    end

endmodule

// File: tb/tb_bicubic_tap_loader.sv
// Scoreboard bench for bicubic_tap_loader: SRAM returns the column index,
// a small engine model answers eng_start; honours BORDER_MIRROR_EN.
module tb_bicubic_tap_loader;

    localparam int IMG_W  = 64;
    localparam int IMG_H  = 64;
    localparam int COL_W  = 6;
    localparam int ROW_W  = 6;
    localparam int ADDR_W = 12;

    typedef struct packed {
        logic [47:0] addrs;
        logic [31:0] p;
        logic [31:0] x;
        logic [7:0]  res;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [COL_W-1:0]  req_col = '0;
    logic [ROW_W-1:0]  req_row = '0;
    logic [7:0]        req_frac = 8'd0;
    logic              mem_ren;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_rdata = 8'd0;
    logic [31:0]       eng_x;
    logic [31:0]       eng_p;
    logic              eng_start;
    logic              eng_finish = 1'b0;
    logic [7:0]        eng_out_val = 8'd0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [7:0]        res_data;

    int   total = 0;
    int   bad = 0;
    exp_t exp_q[$];

    bicubic_tap_loader #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .COL_W(COL_W), .ROW_W(ROW_W), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_col(req_col), .req_row(req_row), .req_frac(req_frac),
        .mem_ren(mem_ren), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .eng_x(eng_x), .eng_p(eng_p), .eng_start(eng_start),
        .eng_finish(eng_finish), .eng_out_val(eng_out_val),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data)
    );

    always #5 clk = ~clk;

    // SRAM model: one-cycle read latency, content = column index.
    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= {2'b00, mem_addr[5:0]};
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic int map_col(input int c);
`ifdef BORDER_MIRROR_EN
        if (c < 0) return -c;
        if (c > IMG_W - 1) return 2 * (IMG_W - 1) - c;
        return c;
`else
        if (c < 0) return 0;
        if (c > IMG_W - 1) return IMG_W - 1;
        return c;
`endif
    endfunction

    function automatic logic [7:0] rmul(input logic [7:0] a, input logic [7:0] b);
        int v;
        v = (int'(a) * int'(b) + 128) / 256;
        return v[7:0];
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_mem_ren"},   32'(mem_ren),   32'd0);
        check({tag, "_mem_addr"},  32'(mem_addr),  32'd0);
        check({tag, "_eng_x"},     eng_x,          32'd0);
        check({tag, "_eng_p"},     eng_p,          32'd0);
        check({tag, "_eng_start"}, 32'(eng_start), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_data"},  32'(res_data),  32'd0);
    endtask

    task automatic do_req(input int col, input int row, input logic [7:0] frac,
                          input logic [7:0] rval, input int hold, input bit abort);
        exp_t        e;
        exp_t        got_e;
        logic [47:0] got_ad;
        logic [7:0]  t2;
        int          c, n, cyc, na;
        for (int i = 0; i < 4; i++) begin
            c = map_col(col - 1 + i);
            e.addrs[12*i +: 12] = 12'(row * IMG_W + c);
            e.p[8*i +: 8]       = 8'(c);
        end
        t2    = rmul(frac, frac);
        e.x   = {8'hFF, frac, t2, rmul(t2, frac)};
        e.res = rval;
        exp_q.push_back(e);

        @(negedge clk);
        req_col = COL_W'(col); req_row = ROW_W'(row); req_frac = frac; req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("accept_bound", 32'(n < 20), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("busy_ready", 32'(req_ready), 32'd0);
        cyc = 1; na = 0; got_ad = 48'd0;
        while (cyc < 16 && eng_start !== 1'b1) begin
            if (mem_ren === 1'b1) begin
                if (na < 4) got_ad[12*na +: 12] = mem_addr;
                na++;
            end
            @(negedge clk);
            cyc++;
        end
        check("start_latency", 32'(cyc), 32'd6);
        check("read_count", 32'(na), 32'd4);
        got_e = exp_q.pop_front();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("addr%0d_c%0d", i, col), 32'(got_ad[12*i +: 12]), 32'(got_e.addrs[12*i +: 12]));
        end
        check($sformatf("eng_p_c%0d", col), eng_p, got_e.p);
        check($sformatf("eng_x_f%0h", frac), eng_x, got_e.x);
        @(negedge clk);
        check("start_pulse_len", 32'(eng_start), 32'd0);

        if (abort) begin
            rst = 1'b1;
            @(negedge clk);
            check_reset_outputs("midrst");
            rst = 1'b0;
            repeat (2) @(negedge clk);
            eng_finish = 1'b1; eng_out_val = rval;
            @(negedge clk);
            eng_finish = 1'b0;
            for (int k = 0; k < 4; k++) begin
                check("late_finish_valid", 32'(res_valid), 32'd0);
                check("late_finish_ready", 32'(req_ready), 32'd1);
                @(negedge clk);
            end
            return;
        end

        @(negedge clk);
        eng_finish = 1'b1; eng_out_val = rval;
        @(negedge clk);
        eng_finish = 1'b0;
        check("res_valid_lat", 32'(res_valid), 32'd1);
        check("res_data", 32'(res_data), 32'(got_e.res));
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(res_valid), 32'd1);
            check("hold_data", 32'(res_data), 32'(got_e.res));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check("drain_valid", 32'(res_valid), 32'd0);
        check("drain_ready", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_ready", 32'(req_ready), 32'd1);

        // Spurious finish while idle.
        eng_finish = 1'b1; eng_out_val = 8'h77;
        @(negedge clk);
        eng_finish = 1'b0;
        check("spurious_valid", 32'(res_valid), 32'd0);
        check("spurious_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("spurious_valid2", 32'(res_valid), 32'd0);

        do_req(10, 3, 8'h80, 8'h3C, 0, 1'b0);
        do_req(0,  0, 8'h33, 8'h11, 0, 1'b0);
        do_req(63, 5, 8'hFF, 8'h22, 0, 1'b0);
        do_req(62, 7, 8'h01, 8'h33, 0, 1'b0);
        do_req(1,  9, 8'hC0, 8'h44, 0, 1'b0);
        do_req(20, 2, 8'h40, 8'hA5, 5, 1'b0);
        for (int r = 0; r < 4; r++) begin
            do_req(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)),
                   8'($urandom), 8'($urandom), int'($urandom_range(0, 2)), 1'b0);
        end
        do_req(30, 4, 8'h9A, 8'h5A, 0, 1'b1);
        do_req(5, 6, 8'h70, 8'h66, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
